// File: rtl/rev_gate_pipe_pkg.sv
// rev_pkg: shared types, limits and per-lane gate functions for rev_gate_pipe.
// Each function evaluates one bit-lane of the three wires and returns {p, q, r}.
package rev_pkg;

  localparam int unsigned MIN_WIDTH  = 1;
  localparam int unsigned MAX_WIDTH  = 64;
  localparam int unsigned MIN_STAGES = 1;
  localparam int unsigned MAX_STAGES = 4;

  typedef enum logic [1:0] {
    OP_CNOT  = 2'b00,
    OP_TOFF  = 2'b01,
    OP_FRED  = 2'b10,
    OP_PERES = 2'b11
  } op_e;

  // Forward gate on one lane; inv only matters for Peres (the others are self-inverse).
  function automatic logic [2:0] rev_fwd(op_e op, logic inv, logic a, logic b, logic c);
    logic p, q, r;
    p = a;
    q = b;
    r = c;
    case (op)
      OP_CNOT:  q = a ^ b;
      OP_TOFF:  r = c ^ (a & b);
      OP_FRED: begin
        q = (b & ~a) | (c & a);
        r = (c & ~a) | (b & a);
      end
      default: begin
        q = a ^ b;
        r = inv ? (c ^ (a & (a ^ b))) : (c ^ (a & b));
      end
    endcase
    return {p, q, r};
  endfunction

  // Undo rev_fwd(op, inv, ...) on one lane: recovers {a, b, c} from {p, q, r}.
  function automatic logic [2:0] rev_inv(op_e op, logic inv, logic p, logic q, logic r);
    logic a, b, c;
    a = p;
    b = q;
    c = r;
    case (op)
      OP_CNOT:  b = p ^ q;
      OP_TOFF:  c = r ^ (p & q);
      OP_FRED: begin
        b = (q & ~p) | (r & p);
        c = (r & ~p) | (q & p);
      end
      default: begin
        b = p ^ q;
        c = inv ? (r ^ (p & q)) : (r ^ (p & (p ^ q)));
      end
    endcase
    return {a, b, c};
  endfunction

endpackage

// File: rtl/rev_gate_pipe_if.sv
// Beat interface of rev_gate_pipe: input beat (op/inv/a/b/c) and output beat (p/q/r),
// each with its own valid/ready handshake.
interface rev_gate_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic             inv;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] p_out;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;

  modport master (
    output in_valid, op, inv, a_in, b_in, c_in, out_ready,
    input  in_ready, out_valid, p_out, q_out, r_out
  );

  modport slave (
    input  in_valid, op, inv, a_in, b_in, c_in, out_ready,
    output in_ready, out_valid, p_out, q_out, r_out
  );
endinterface

// File: rtl/rev_gate_pipe_stage.sv
// rev_pipe_stage: one elastic register slot. Loads when empty or when the
// downstream slot takes the current beat in the same cycle.
module rev_pipe_stage #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);
  logic          valid_q, valid_d;
  logic [PW-1:0] data_q, data_d;
  logic          load;

  // Slot control: accept on handshake, drain when downstream takes the beat
  always_comb begin
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = load ? 1'b1 : (valid_q && !out_ready);
    data_d   = load ? in_data : data_q;
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/rev_gate_pipe.sv
// rev_gate_pipe: WIDTH-lane reversible gate array (CNOT/Toffoli/Fredkin/Peres)
// behind a STAGES-deep elastic pipeline with an accepted-beat counter.
// Optional reversibility checker: define REV_GATE_PIPE_CHECK_EN.
module rev_gate_pipe
  import rev_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rev_gate_pipe_if.slave   bus,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             chk_err
);
`ifdef REV_GATE_PIPE_CHECK_EN
  localparam int unsigned PW = 6 * WIDTH + 3;
`else
  localparam int unsigned PW = 3 * WIDTH;
`endif

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("rev_gate_pipe: WIDTH out of range");
  end
  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("rev_gate_pipe: STAGES out of range");
  end

  logic [WIDTH-1:0] g_p, g_q, g_r;
  logic [2:0]       lane_f;
  logic [PW-1:0]    payload_in;
  logic [PW-1:0]    out_data;
  logic [WIDTH-1:0] out_p, out_q, out_r;
  logic             in_rdy, out_vld, accept;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Evaluate the selected gate lane by lane on the incoming beat
  always_comb begin
    g_p    = '0;
    g_q    = '0;
    g_r    = '0;
    lane_f = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      lane_f = rev_fwd(op_e'(bus.op), bus.inv, bus.a_in[i], bus.b_in[i], bus.c_in[i]);
      {g_p[i], g_q[i], g_r[i]} = lane_f;
    end
  end

`ifdef REV_GATE_PIPE_CHECK_EN
  assign payload_in = {bus.op, bus.inv, bus.a_in, bus.b_in, bus.c_in, g_p, g_q, g_r};
`else
  assign payload_in = {g_p, g_q, g_r};
`endif

  // Ready ripples back from the output through per-stage signals rather than a
  // shared vector so the chain never looks like a self-dependent net.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic          vld_in, rdy_in, vld_out, rdy_out;
    logic [PW-1:0] dat_in, dat_out;

    if (g == 0) begin : g_head
      assign vld_in = bus.in_valid;
      assign dat_in = payload_in;
    end else begin : g_link
      assign vld_in = g_stage[g-1].vld_out;
      assign dat_in = g_stage[g-1].dat_out;
    end

    if (g == STAGES - 1) begin : g_tail
      assign rdy_out = bus.out_ready;
    end else begin : g_mid
      assign rdy_out = g_stage[g+1].rdy_in;
    end

    rev_pipe_stage #(.PW(PW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld_in),
      .in_ready  (rdy_in),
      .in_data   (dat_in),
      .out_valid (vld_out),
      .out_ready (rdy_out),
      .out_data  (dat_out)
    );
  end

  assign in_rdy   = g_stage[0].rdy_in;
  assign out_vld  = g_stage[STAGES-1].vld_out;
  assign out_data = g_stage[STAGES-1].dat_out;
  assign accept   = bus.in_valid && in_rdy;
  assign {out_p, out_q, out_r} = out_data[3*WIDTH-1:0];

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.p_out     = out_p;
  assign bus.q_out     = out_q;
  assign bus.r_out     = out_r;

  // Accepted-beat counter, wraps naturally at 2^CNT_W
  always_comb begin
    beat_cnt_d = accept ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;

`ifdef REV_GATE_PIPE_CHECK_EN
  logic [1:0]       chk_op;
  logic             chk_inv;
  logic [WIDTH-1:0] chk_a, chk_b, chk_c;
  logic [WIDTH-1:0] inv_a, inv_b, inv_c;
  logic [2:0]       lane_i;
  logic             chk_err_q, chk_err_d;

  assign {chk_op, chk_inv, chk_a, chk_b, chk_c} = out_data[PW-1:3*WIDTH];

  // Undo the gate at the output and flag any beat that does not round-trip
  always_comb begin
    inv_a  = '0;
    inv_b  = '0;
    inv_c  = '0;
    lane_i = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      lane_i = rev_inv(op_e'(chk_op), chk_inv, out_p[i], out_q[i], out_r[i]);
      {inv_a[i], inv_b[i], inv_c[i]} = lane_i;
    end
    chk_err_d = chk_err_q || (out_vld && ({inv_a, inv_b, inv_c} != {chk_a, chk_b, chk_c}));
  end

  // Sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_rev_gate_pipe.sv
// Directed self-checking bench for rev_gate_pipe (WIDTH=8, STAGES=2) plus a
// CNT_W=4 instance for counter wrap.
module tb_rev_gate_pipe;
  logic        clk;
  logic        rst_n;
  logic [15:0] beat_cnt;
  logic        chk_err;
  logic [3:0]  beat_cnt_w;
  logic        chk_err_w;
  int          n_cmp;
  int          n_err;

  rev_gate_pipe_if #(.WIDTH(8)) u_if ();
  rev_gate_pipe_if #(.WIDTH(8)) u_if_w ();

  rev_gate_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (u_if),
    .beat_cnt (beat_cnt),
    .chk_err  (chk_err)
  );

  rev_gate_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (u_if_w),
    .beat_cnt (beat_cnt_w),
    .chk_err  (chk_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    u_if.in_valid = 1'b0;  u_if.op = 2'b00;  u_if.inv = 1'b0;
    u_if.a_in = '0;  u_if.b_in = '0;  u_if.c_in = '0;  u_if.out_ready = 1'b1;
    u_if_w.in_valid = 1'b0;  u_if_w.op = 2'b00;  u_if_w.inv = 1'b0;
    u_if_w.a_in = '0;  u_if_w.b_in = '0;  u_if_w.c_in = '0;  u_if_w.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 6;
    if (u_if.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b want=1", u_if.in_ready); end
    if (u_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b want=0", u_if.out_valid); end
    if ({u_if.p_out, u_if.q_out, u_if.r_out} !== 24'h0) begin
      n_err++; $display("FAIL rst_pqr got=%h want=000000", {u_if.p_out, u_if.q_out, u_if.r_out});
    end
    if (beat_cnt !== 16'd0) begin n_err++; $display("FAIL rst_beat_cnt got=%0d want=0", beat_cnt); end
    if (chk_err !== 1'b0) begin n_err++; $display("FAIL rst_chk_err got=%b want=0", chk_err); end
    if (beat_cnt_w !== 4'd0) begin n_err++; $display("FAIL rst_beat_cnt_w got=%0d want=0", beat_cnt_w); end
  endtask

  // One beat through the empty pipe; checks latency, outputs and chk_err.
  task automatic run_gate(input string name, input logic [1:0] op, input logic inv,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] ep, input logic [7:0] eq, input logic [7:0] er);
    int lat;
    bit got;
    u_if.op = op;  u_if.inv = inv;  u_if.a_in = a;  u_if.b_in = b;  u_if.c_in = c;
    u_if.in_valid = 1'b1;  u_if.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (u_if.in_ready !== 1'b1) begin n_err++; $display("FAIL %s in_ready got=%b want=1", name, u_if.in_ready); end
    @(posedge clk);
    #1 u_if.in_valid = 1'b0;
    u_if.op = 2'b11;  u_if.inv = ~inv;  u_if.a_in = 8'hDE;  u_if.b_in = 8'hAD;  u_if.c_in = 8'hBE;
    lat = 1;
    got = 1'b0;
    while (lat <= 8 && !got) begin
      @(negedge clk);
      if (u_if.out_valid === 1'b1) got = 1'b1;
      else lat++;
    end
    n_cmp += 3;
    if (lat != 2) begin n_err++; $display("FAIL %s latency got=%0d want=2", name, lat); end
    if ({u_if.p_out, u_if.q_out, u_if.r_out} !== {ep, eq, er}) begin
      n_err++;
      $display("FAIL %s pqr got=%h_%h_%h want=%h_%h_%h", name, u_if.p_out, u_if.q_out, u_if.r_out, ep, eq, er);
    end
    if (chk_err !== 1'b0) begin n_err++; $display("FAIL %s chk_err got=%b want=0", name, chk_err); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_gates();
    do_reset();
    run_gate("cnot",      2'b00, 1'b0, 8'hF0, 8'h3C, 8'h11, 8'hF0, 8'hCC, 8'h11);
    run_gate("cnot_inv",  2'b00, 1'b1, 8'hF0, 8'h3C, 8'h11, 8'hF0, 8'hCC, 8'h11);
    run_gate("toffoli",   2'b01, 1'b0, 8'hFF, 8'h0F, 8'h00, 8'hFF, 8'h0F, 8'h0F);
    run_gate("toff_inv",  2'b01, 1'b1, 8'h3C, 8'h0F, 8'hFF, 8'h3C, 8'h0F, 8'hF3);
    run_gate("fredkin",   2'b10, 1'b0, 8'hAA, 8'hFF, 8'h00, 8'hAA, 8'h55, 8'hAA);
    run_gate("fred_a0",   2'b10, 1'b1, 8'h00, 8'h12, 8'h34, 8'h00, 8'h12, 8'h34);
    run_gate("peres_fwd", 2'b11, 1'b0, 8'h0F, 8'h33, 8'h00, 8'h0F, 8'h3C, 8'h03);
    run_gate("peres_inv", 2'b11, 1'b1, 8'h0F, 8'h3C, 8'h03, 8'h0F, 8'h33, 8'h00);
    run_gate("peres_inv2",2'b11, 1'b1, 8'hFF, 8'h0F, 8'hF0, 8'hFF, 8'hF0, 8'h00);
    n_cmp++;
    if (beat_cnt !== 16'd9) begin n_err++; $display("FAIL gates_beat_cnt got=%0d want=9", beat_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [4];
    logic [7:0] tq [4];
    logic [7:0] tc [4];
    int sent;
    int recv;
    ta = '{8'h11, 8'h22, 8'h33, 8'h44};
    tq = '{8'h1E, 8'h2D, 8'h3C, 8'h4B};
    tc = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_reset();
    sent = 0;
    recv = 0;
    for (int t = 0; t < 12; t++) begin
      u_if.in_valid = (sent < 4);
      u_if.op = 2'b00;  u_if.inv = 1'b0;
      u_if.a_in = ta[sent % 4];  u_if.b_in = 8'h0F;  u_if.c_in = tc[sent % 4];
      @(negedge clk);
      if (u_if.in_valid) begin
        n_cmp++;
        if (u_if.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b in_ready t=%0d got=%b want=1", t, u_if.in_ready); end
        else sent++;
      end
      if (u_if.out_valid === 1'b1 && recv < 4) begin
        n_cmp += 2;
        if (t != recv + 2) begin n_err++; $display("FAIL b2b timing beat=%0d got_t=%0d want_t=%0d", recv, t, recv + 2); end
        if ({u_if.p_out, u_if.q_out, u_if.r_out} !== {ta[recv], tq[recv], tc[recv]}) begin
          n_err++;
          $display("FAIL b2b data beat=%0d got=%h_%h_%h want=%h_%h_%h", recv,
                   u_if.p_out, u_if.q_out, u_if.r_out, ta[recv], tq[recv], tc[recv]);
        end
        recv++;
      end
      @(posedge clk);
      #1;
    end
    u_if.in_valid = 1'b0;
    n_cmp++;
    if (recv != 4) begin n_err++; $display("FAIL b2b count got=%0d want=4", recv); end
  endtask

  task automatic test_backpressure();
    int sent;
    int recv;
    int t;
    logic [23:0] held;
    bit saw_stall_block;
    do_reset();
    sent = 0;
    recv = 0;
    t = 0;
    held = '0;
    saw_stall_block = 1'b0;
    while (recv < 10 && t < 60) begin
      u_if.in_valid  = (sent < 10);
      u_if.op = 2'b00;  u_if.inv = 1'b0;
      u_if.a_in = 8'(sent);  u_if.b_in = 8'h55;  u_if.c_in = ~8'(sent);
      u_if.out_ready = !(t >= 3 && t <= 7);
      @(negedge clk);
      if (t >= 3 && t <= 7) begin
        n_cmp += 3;
        if (u_if.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready t=%0d got=%b want=0", t, u_if.in_ready); end
        else saw_stall_block = 1'b1;
        if (sent - recv != 2) begin n_err++; $display("FAIL bp_occupancy t=%0d got=%0d want=2", t, sent - recv); end
        if (t == 3) held = {u_if.p_out, u_if.q_out, u_if.r_out};
        if ({u_if.p_out, u_if.q_out, u_if.r_out} !== 24'h01_54_FE) begin
          n_err++; $display("FAIL bp_hold t=%0d got=%h want=0154fe", t, {u_if.p_out, u_if.q_out, u_if.r_out});
        end
      end
      if (u_if.in_valid && u_if.in_ready === 1'b1) sent++;
      if (u_if.out_valid === 1'b1 && u_if.out_ready) begin
        n_cmp++;
        if ({u_if.p_out, u_if.q_out, u_if.r_out} !== {8'(recv), 8'(recv) ^ 8'h55, ~8'(recv)}) begin
          n_err++;
          $display("FAIL bp_data beat=%0d got=%h want=%h", recv, {u_if.p_out, u_if.q_out, u_if.r_out},
                   {8'(recv), 8'(recv) ^ 8'h55, ~8'(recv)});
        end
        recv++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b1;
    n_cmp += 4;
    if (recv != 10) begin n_err++; $display("FAIL bp_delivered got=%0d want=10", recv); end
    if (beat_cnt !== 16'd10) begin n_err++; $display("FAIL bp_beat_cnt got=%0d want=10", beat_cnt); end
    if (!saw_stall_block) begin n_err++; $display("FAIL bp_stall_seen got=0 want=1"); end
    if (held !== 24'h01_54_FE) begin n_err++; $display("FAIL bp_held_beat got=%h want=0154fe", held); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    u_if.out_ready = 1'b0;
    u_if.op = 2'b01;  u_if.a_in = 8'hFF;  u_if.b_in = 8'hFF;  u_if.c_in = 8'h00;
    u_if.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 u_if.in_valid = 1'b0;
    n_cmp += 2;
    if (u_if.out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid got=%b want=1", u_if.out_valid); end
    if (beat_cnt !== 16'd2) begin n_err++; $display("FAIL rmid_pre_cnt got=%0d want=2", beat_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (u_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_async_valid got=%b want=0", u_if.out_valid); end
    if (beat_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_async_cnt got=%0d want=0", beat_cnt); end
    if (u_if.r_out !== 8'h00) begin n_err++; $display("FAIL rmid_async_r got=%h want=00", u_if.r_out); end
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (u_if.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale k=%0d got=%b want=0", k, u_if.out_valid); end
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (beat_cnt !== 16'd0) begin n_err++; $display("FAIL rmid_post_cnt got=%0d want=0", beat_cnt); end
  endtask

  task automatic test_wrap();
    int acc;
    int cyc;
    do_reset();
    acc = 0;
    cyc = 0;
    u_if_w.in_valid = 1'b1;
    u_if_w.a_in = 8'h5A;
    while (acc < 17 && cyc < 40) begin
      @(negedge clk);
      if (u_if_w.in_ready === 1'b1) acc++;
      @(posedge clk);
      #1;
      cyc++;
      if (acc == 16 && u_if_w.in_valid) begin
        n_cmp++;
        if (beat_cnt_w !== 4'd0) begin n_err++; $display("FAIL wrap_16 got=%0d want=0", beat_cnt_w); end
      end
      if (acc == 17) u_if_w.in_valid = 1'b0;
    end
    u_if_w.in_valid = 1'b0;
    n_cmp += 3;
    if (acc != 17) begin n_err++; $display("FAIL wrap_accepts got=%0d want=17", acc); end
    if (beat_cnt_w !== 4'd1) begin n_err++; $display("FAIL wrap_17 got=%0d want=1", beat_cnt_w); end
    if (chk_err_w !== 1'b0) begin n_err++; $display("FAIL wrap_chk_err got=%b want=0", chk_err_w); end
  endtask

`ifdef REV_GATE_PIPE_CHECK_EN
  task automatic test_checker();
    int w;
    do_reset();
    u_if.out_ready = 1'b0;
    u_if.op = 2'b00;  u_if.inv = 1'b0;  u_if.a_in = 8'hF0;  u_if.b_in = 8'h3C;  u_if.c_in = 8'h11;
    u_if.in_valid = 1'b1;
    @(posedge clk);
    #1 u_if.in_valid = 1'b0;
    w = 0;
    while (u_if.out_valid !== 1'b1 && w < 10) begin
      @(posedge clk);
      #1 w++;
    end
    n_cmp += 2;
    if (u_if.out_valid !== 1'b1) begin n_err++; $display("FAIL chk_wait got=%b want=1", u_if.out_valid); end
    if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_clean got=%b want=0", chk_err); end
    force dut.out_q = 8'h5A;
    @(posedge clk);
    #1;
    n_cmp++;
    if (chk_err !== 1'b1) begin n_err++; $display("FAIL chk_detect got=%b want=1", chk_err); end
    release dut.out_q;
    u_if.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (chk_err !== 1'b1) begin n_err++; $display("FAIL chk_sticky got=%b want=1", chk_err); end
    do_reset();
    n_cmp++;
    if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_reset got=%b want=0", chk_err); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_gates();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_wrap();
`ifdef REV_GATE_PIPE_CHECK_EN
    test_checker();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
